// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - debounced 4-bit count sequence monitor with serial hex display
module count_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int SCLK_DIV      = 8,
  parameter int REFRESH       = 1024
) (
  input  logic       gclk,
  input  logic       reset,
  input  logic [3:0] dio_in,
  output logic       hex_sclk,
  output logic       hex_sdo,
  output logic       hex_latch,
  output logic [3:0] last_value,
  output logic       locked,
  output logic [7:0] error_count,
  output logic       err_pulse
);

  localparam logic [7:0]  STABLE_N     = 8'(STABLE_CYCLES);
  localparam logic [7:0]  DIV_LAST     = 8'(SCLK_DIV - 1);
  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} disp_state_t;

  logic [3:0]  sync1;
  logic [3:0]  s;
  logic [3:0]  candidate;
  logic [7:0]  stable_cnt;
  logic [7:0]  stable_next;
  logic        accept;
  logic        seq_err;

  disp_state_t state;
  disp_state_t state_next;
  logic [15:0] refresh_cnt;
  logic [7:0]  div_cnt;
  logic        phase;
  logic [3:0]  bit_cnt;
  logic [15:0] frame;
  logic        div_wrap;

  // stable_cnt saturates at STABLE_N so a held value is accepted only once
  always_comb begin
    stable_next = 8'd1;
    if (s == candidate) begin
      stable_next = (stable_cnt == STABLE_N) ? stable_cnt : stable_cnt + 8'd1;
    end
    accept  = (stable_next == STABLE_N) &&
              ((s != candidate) || (stable_cnt != STABLE_N)) &&
              (!locked || (s != last_value));
    seq_err = accept && locked && (s != last_value + 4'd1);
  end

  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      sync1       <= 4'd0;
      s           <= 4'd0;
      candidate   <= 4'd0;
      stable_cnt  <= 8'd0;
      last_value  <= 4'd0;
      locked      <= 1'b0;
      error_count <= 8'd0;
      err_pulse   <= 1'b0;
    end else begin
      sync1      <= dio_in;
      s          <= sync1;
      candidate  <= s;
      stable_cnt <= stable_next;
      err_pulse  <= seq_err;
      if (accept) begin
        last_value <= s;
        locked     <= 1'b1;
      end
      if (seq_err && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'd1;
      end
    end
  end

  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    div_wrap   = (div_cnt == DIV_LAST);
    case (state)
      IDLE:    if (refresh_cnt == REFRESH_LAST) state_next = SHIFT;
      SHIFT:   if (div_wrap && phase && (bit_cnt == 4'd15)) state_next = LATCH;
      LATCH:   if (div_wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    hex_sclk  = (state == SHIFT) && phase;
    hex_sdo   = (state == SHIFT) && frame[15];
    hex_latch = (state == LATCH);
  end

  // frame is shifted at the end of each high phase, so hex_sdo changes at the start of the low phase
  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= 16'd0;
      div_cnt     <= 8'd0;
      phase       <= 1'b0;
      bit_cnt     <= 4'd0;
      frame       <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= 8'd0;
          phase   <= 1'b0;
          bit_cnt <= 4'd0;
          if (state_next == SHIFT) begin
            refresh_cnt <= 16'd0;
            frame       <= {last_value, locked, 3'b000, error_count};
          end else begin
            refresh_cnt <= refresh_cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div_cnt <= 8'd0;
            phase   <= ~phase;
            if (phase) begin
              bit_cnt <= bit_cnt + 4'd1;
              frame   <= {frame[14:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        LATCH: begin
          refresh_cnt <= 16'd0;
          div_cnt     <= div_wrap ? 8'd0 : div_cnt + 8'd1;
        end
        default: begin
          div_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - randomized and directed checks of count_monitor against a run-length model
module tb_count_monitor;
  localparam int S   = 4;
  localparam int DIV = 2;
  localparam int REF = 16;

  logic       gclk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] dio_in = 4'd0;
  logic       hex_sclk, hex_sdo, hex_latch, locked, err_pulse;
  logic [3:0] last_value;
  logic [7:0] error_count;

  int checks = 0;
  int errors = 0;

  // reference model: value stream delayed two cycles, split into runs
  logic [3:0] m_sync1, m_sync2, m_run_val, m_last;
  int         m_run_len, m_errs, err_seen;
  logic       m_locked, m_err;

  logic [3:0]  prev_v, v;
  logic [15:0] bits;
  int          len, pulses, gap, latch_cycles, first_rise;
  logic        found, done, prev_l, ps, lat_bad;

  count_monitor #(.STABLE_CYCLES(S), .SCLK_DIV(DIV), .REFRESH(REF)) dut (
    .gclk(gclk), .reset(reset), .dio_in(dio_in),
    .hex_sclk(hex_sclk), .hex_sdo(hex_sdo), .hex_latch(hex_latch),
    .last_value(last_value), .locked(locked),
    .error_count(error_count), .err_pulse(err_pulse)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 0; m_sync2 = 0; m_run_val = 0; m_run_len = 0;
    m_last = 0; m_locked = 0; m_errs = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic [3:0] nv);
    logic [3:0] seen;
    seen    = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = nv;
    if (seen == m_run_val) m_run_len++;
    else begin
      m_run_val = seen;
      m_run_len = 1;
    end
    m_err = 0;
    if (m_run_len == S && (!m_locked || m_run_val != m_last)) begin
      if (m_locked && int'(m_run_val) != (int'(m_last) + 1) % 16) begin
        m_err = 1;
        if (m_errs < 255) m_errs++;
      end
      m_last   = m_run_val;
      m_locked = 1;
    end
  endtask

  task automatic tick(input logic [3:0] nv);
    dio_in = nv;
    @(posedge gclk);
    if (reset) model_edge(nv);
    else model_reset();
    #1;
    chk("last_value", last_value, m_last);
    chk("locked", locked, m_locked);
    chk("error_count", error_count, m_errs);
    chk("err_pulse", err_pulse, m_err);
    if (err_pulse) err_seen++;
  endtask

  task automatic hold(input logic [3:0] nv, input int n);
    repeat (n) tick(nv);
  endtask

  task automatic do_reset(input logic [3:0] nv);
    reset = 1'b0;
    model_reset();
    hold(nv, 3);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    err_seen = 0;
    // reset release with 3 already present: accepted on the sixth edge
    do_reset(4'd3);
    hold(4'd3, 5);
    chk("req030_early_lv", last_value, 4'd0);
    chk("req030_early_lock", locked, 1'b0);
    tick(4'd3);
    chk("req030_lv", last_value, 4'd3);
    chk("req030_lock", locked, 1'b1);
    chk("req030_errs", error_count, 8'd0);

    // full legal sequence with wrap
    do_reset(4'd0);
    err_seen = 0;
    for (int i = 0; i < 18; i++) hold(4'(i % 16), 10);
    chk("req031_errs", error_count, 8'd0);
    chk("req031_pulses", err_seen, 0);
    chk("req031_lv", last_value, 4'd1);

    // one sequence error then a short glitch
    do_reset(4'd5);
    hold(4'd5, 10);
    err_seen = 0;
    hold(4'd9, 10);
    chk("req032_pulses", err_seen, 1);
    chk("req032_errs", error_count, 8'd1);
    chk("req032_lv", last_value, 4'd9);
    hold(4'd6, 2);
    hold(4'd9, 10);
    chk("glitch_pulses", err_seen, 1);
    chk("glitch_errs", error_count, 8'd1);
    chk("glitch_lv", last_value, 4'd9);

    // 300 errors saturate the counter
    do_reset(4'd0);
    hold(4'd0, 8);
    err_seen = 0;
    for (int i = 0; i < 300; i++) hold((i % 2) ? 4'd0 : 4'd5, 5);
    hold(4'd0, 6);
    chk("req033_pulses", err_seen, 300);
    chk("req033_errs", error_count, 8'd255);

    // randomized runs, some shorter than the stability window
    do_reset(4'd0);
    prev_v = 4'd0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) v = prev_v + 4'd1;
      else begin
        v = 4'($urandom_range(0, 15));
        if (v == prev_v) v = prev_v + 4'd3;
      end
      len = $urandom_range(1, 8);
      hold(v, len);
      prev_v = v;
    end
    hold(prev_v, 8);

    // display frame: last_value=A, locked, error_count=3
    do_reset(4'd0);
    hold(4'd5, 8); hold(4'd8, 8); hold(4'd1, 8); hold(4'd9, 8); hold(4'd10, 8);
    chk("frame_setup_errs", error_count, 8'd3);
    chk("frame_setup_lv", last_value, 4'hA);
    found = 0;
    prev_l = hex_latch;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(4'd10);
      if (prev_l && !hex_latch) found = 1;
      prev_l = hex_latch;
    end
    chk("frame_sync", found, 1'b1);
    bits = 0; pulses = 0; gap = 0; latch_cycles = 0; done = 0; lat_bad = 0;
    ps = hex_sclk;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(4'd10);
      if (!hex_latch) begin
        if (latch_cycles == 0) gap++;
        else done = 1;
      end else begin
        latch_cycles++;
        if (hex_sclk || hex_sdo) lat_bad = 1;
      end
      if (hex_sclk && !ps) begin
        bits = {bits[14:0], hex_sdo};
        pulses++;
      end
      ps = hex_sclk;
    end
    chk("frame_done", done, 1'b1);
    chk("frame_bits", bits, 16'hA803);
    chk("frame_pulses", pulses, 16);
    chk("frame_latch_len", latch_cycles, DIV);
    chk("frame_gap", gap, REF + 32 * DIV - 1);
    chk("latch_quiet", lat_bad, 1'b0);

    // reset in the middle of SHIFT
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(4'd10);
      if (hex_sclk) found = 1;
    end
    chk("shift_found", found, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_sclk", hex_sclk, 1'b0);
    chk("rst_sdo", hex_sdo, 1'b0);
    chk("rst_latch", hex_latch, 1'b0);
    chk("rst_lv", last_value, 4'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_errs", error_count, 8'd0);
    chk("rst_pulse", err_pulse, 1'b0);
    hold(4'd10, 3);
    reset = 1'b1;
    first_rise = 0;
    for (int i = 1; i <= 100 && first_rise == 0; i++) begin
      tick(4'd10);
      if (hex_sclk) first_rise = i;
    end
    chk("post_rst_first_sclk", first_rise, REF + DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
